peak_meter: RTL
===============

# peak_meter

Log-scale level meter with fast attack, timed decay and a peak-hold marker. It sits directly downstream of `peak_detect` and consumes its 23-bit rectified, channel-averaged `peak` word. It produces a thermometer bar and a hold-marker index for the logo/overlay renderer. All logic runs in the `wclk` domain at the audio word rate.

## Interface
- `NSEG`, 16, number of bar segments; legal range 1..23.
- `DECAY_DIV`, 48000, `wclk` cycles per decay tick.
- `HOLD_STEPS`, 32, decay ticks the hold marker stays frozen before falling; must be ≥1.
- `wclk`  in  1  clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-high. All state clears immediately on assertion.
- `en`  in  1  sample strobe; `peak` is captured on cycles with `en`=1.
- `peak`  in  23  unsigned magnitude from the peak detector.
- `level`  out  5  instantaneous log level, 0..23.
- `bar`  out  NSEG  thermometer; `bar[i]`=1 iff i < cur.
- `hold_seg`  out  5  hold-marker segment, 0 = no marker, else 1..NSEG.
- `upd`  out  1  one-cycle pulse after `cur` or `hold_seg` changes.

## Operation
- **Stage 1:** when `en`=1, `pk_r` <= `peak`; `sv1` <= `en`.
- **Stage 2:** `lvl_r` <= 0 if `pk_r`==0, else (index of the leading one)+1, giving 1..23. `sv2` <= `sv1`. `level` = `lvl_r`.
- **Stage 3:** OFF = 23−NSEG. `seg_r` <= `lvl_r` − OFF when `lvl_r` > OFF, else 0. `sv3` <= `sv2`. Saturation is explicit; no wrap.
- **Prescaler:** free-running counter 0..DECAY_DIV−1. `tick`=1 on the cycle the counter equals DECAY_DIV−1, then it wraps to 0.
- **Bar register `cur` (0..NSEG):**
  - Attack: if `sv3` and `seg_r` > `cur`, then `cur` <= `seg_r`.
  - Decay: else if `tick` and `cur` > 0 and (`sv3`=0 or `seg_r` < `cur`), then `cur` <= `cur`−1.
  - Attack beats decay in the same cycle. A sample equal to `cur` suppresses that tick's decay.
- **Hold FSM, states IDLE / HOLD / FALL:**
  - **Any state:** if `cur_next` > `hold`, then `hold` <= `cur_next`, `hcnt` <= 0, state <= HOLD. This has priority over all transitions below.
  - **IDLE:** `hold`=0; stays in IDLE until the rule above fires.
  - **HOLD:** on `tick`, `hcnt`++. On the `tick` where `hcnt`==HOLD_STEPS−1, go to FALL and leave `hold` unchanged.
  - **FALL:** on `tick`, `hold` <= max(`hold`−1, `cur_next`). If the result is 0, go to IDLE.
- `hold_seg` = `hold`. The marker is never below the bar.
- `upd` <= (`cur_next` != `cur`) or (`hold_next` != `hold`).

## Timing
- **Reset values:**
  - `level`=0, `bar`=0, `hold_seg`=0, `upd`=0.
  - State IDLE; prescaler, `hcnt`, `sv1..3` and all pipeline registers are 0.
- **Latency:**
  - `en` at edge N → `level` valid after edge N+1.
  - `cur`/`bar` and `hold_seg` updated after edge N+3.
  - `upd` high for the cycle after edge N+4.
- **Back-to-back `en`:** fully pipelined; every cycle is processed.
- **`tick` coinciding with a sample:** resolved by the attack-priority rule above.
- **HOLD restart:** a new maximum during HOLD restarts `hcnt` at 0.
- **Reset mid-operation:** returns everything to reset values asynchronously. The first tick after release is DECAY_DIV cycles later.
- **DECAY_DIV=1:** `tick` is asserted every cycle.

## Structure
- **Package `meter_pkg`:**
  - `LVL_W`=5 and `PK_W`=23.
  - Hold-state enum: IDLE=2'd0, HOLD=2'd1, FALL=2'd2.
  - Function for the OFF computation.
- **Sub-module `msb_encode`:** combinational 23-bit leading-one detector returning a 5-bit level (0 for zero input). It is instantiated in stage 2.

## Test plan
All scenarios use NSEG=16, DECAY_DIV=4, HOLD_STEPS=2.
- **Reset:** assert `rst` mid-stream with `bar`=16'hFFFF → `bar`=0, `hold_seg`=0, `level`=0 immediately, before any clock edge.
- **Level mapping:**
  - `peak`=23'h400000 → `level`=23, `bar`=16'hFFFF.
  - `peak`=23'h000100 → `level`=9, `bar`=16'h0003.
  - `peak`=23'h00007F → `level`=7, `bar`=0.
  - `peak`=0 → `level`=0.
- **Attack latency:** single `en` pulse with 23'h400000 at edge N, from reset → `bar`=16'hFFFF and `hold_seg`=16 after edge N+3; `upd` pulse one cycle later.
- **Decay and hold:** after full scale, feed `peak`=0 continuously → `cur` drops by one every 4 cycles. `hold_seg` stays 16 for 2 ticks, then falls one per tick and never goes below `cur`. Both reach 0 by tick 18, with state returning to IDLE.
- **Simultaneous events:** sample with `seg_r`=`cur` coincident with `tick` → `cur` unchanged. Sample with `seg_r`>`cur` coincident with `tick` → `cur`=`seg_r`.
- **Hold restart:** new maximum 12 arriving during FALL with `hold`=10 → `hold_seg`=12, state HOLD, `hcnt`=0.

Source files
------------

// File: rtl/meter_pkg.sv
// Shared widths, hold-marker state encoding and segment-offset helper
// for the peak_meter level display.
package meter_pkg;

  localparam int LVL_W = 5;
  localparam int PK_W  = 23;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    FALL = 2'd2
  } hold_state_t;

  // Number of low log levels that fall below the first bar segment.
  function automatic logic [LVL_W-1:0] seg_offset(input int nseg);
    return LVL_W'(PK_W - nseg);
  endfunction

endpackage

// File: rtl/msb_encode.sv
// Leading-one detector: maps a 23-bit magnitude to its log level,
// 0 for a zero input, otherwise (index of the highest set bit)+1.
module msb_encode
  import meter_pkg::*;
(
  input  logic [PK_W-1:0]  i_val,
  output logic [LVL_W-1:0] o_lvl
);

  // Scan upward so the highest set bit wins.
  always_comb begin
    o_lvl = '0;
    for (int i = 0; i < PK_W; i++) begin
      o_lvl = i_val[i] ? LVL_W'(i + 1) : o_lvl;
    end
  end

endmodule

// File: rtl/peak_meter.sv
// Log-scale level meter: three-stage level pipeline, fast-attack/timed-decay
// bar register and a peak-hold marker that freezes, then falls toward the bar.
module peak_meter
  import meter_pkg::*;
#(
  parameter int NSEG       = 16,
  parameter int DECAY_DIV  = 48000,
  parameter int HOLD_STEPS = 32
) (
  input  logic             wclk,
  input  logic             rst,
  input  logic             en,
  input  logic [PK_W-1:0]  peak,
  output logic [LVL_W-1:0] level,
  output logic [NSEG-1:0]  bar,
  output logic [LVL_W-1:0] hold_seg,
  output logic             upd
);

  localparam logic [LVL_W-1:0] OFF     = seg_offset(NSEG);
  localparam int               DIV_W   = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DECAY_DIV - 1);
  localparam int               HC_W    = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [HC_W-1:0]  HC_MAX  = HC_W'(HOLD_STEPS - 1);

  logic [PK_W-1:0]  r_pk;
  logic             r_sv1, r_sv2, r_sv3;
  logic [LVL_W-1:0] r_lvl, r_seg, r_cur, r_hold;
  logic [DIV_W-1:0] r_div;
  logic [HC_W-1:0]  r_hcnt;
  hold_state_t      r_state;
  logic [NSEG-1:0]  r_bar;
  logic             r_chg, r_upd;

  logic [LVL_W-1:0] w_lvl, w_seg_next, w_cur_next, w_hold_next;
  logic [LVL_W-1:0] w_fall_dec, w_fall;
  logic [HC_W-1:0]  w_hcnt_next;
  hold_state_t      w_state_next;
  logic [NSEG-1:0]  w_bar_next;
  logic             w_tick, w_chg;

  msb_encode u_enc (
    .i_val (r_pk),
    .o_lvl (w_lvl)
  );

  assign w_seg_next = (r_lvl > OFF) ? (r_lvl - OFF) : '0;
  assign w_tick     = (r_div == DIV_MAX);

  // Level pipeline: capture, log-encode, map onto segment range.
  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      r_pk  <= '0;
      r_sv1 <= 1'b0;
      r_lvl <= '0;
      r_sv2 <= 1'b0;
      r_seg <= '0;
      r_sv3 <= 1'b0;
    end else begin
      r_pk  <= en ? peak : r_pk;
      r_sv1 <= en;
      r_lvl <= w_lvl;
      r_sv2 <= r_sv1;
      r_seg <= w_seg_next;
      r_sv3 <= r_sv2;
    end
  end

  // Decay prescaler.
  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
    end else begin
      r_div <= w_tick ? '0 : (r_div + DIV_W'(1));
    end
  end

  // Attack beats decay; a sample equal to the bar holds it through the tick.
  always_comb begin
    if (r_sv3 && (r_seg > r_cur)) begin
      w_cur_next = r_seg;
    end else if (w_tick && (r_cur != '0) && (!r_sv3 || (r_seg < r_cur))) begin
      w_cur_next = r_cur - LVL_W'(1);
    end else begin
      w_cur_next = r_cur;
    end
  end

  // Marker falls by one per tick but never below the bar.
  always_comb begin
    w_fall_dec = (r_hold != '0) ? (r_hold - LVL_W'(1)) : '0;
    w_fall     = (w_fall_dec > w_cur_next) ? w_fall_dec : w_cur_next;
  end

  // Hold FSM next state; a new maximum overrides every transition.
  always_comb begin
    w_state_next = r_state;
    w_hold_next  = r_hold;
    w_hcnt_next  = r_hcnt;
    if (w_cur_next > r_hold) begin
      w_hold_next  = w_cur_next;
      w_hcnt_next  = '0;
      w_state_next = HOLD;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_next = IDLE;
        end
        HOLD: begin
          if (w_tick && (r_hcnt == HC_MAX)) begin
            w_state_next = FALL;
          end else if (w_tick) begin
            w_hcnt_next = r_hcnt + HC_W'(1);
          end else begin
            w_hcnt_next = r_hcnt;
          end
        end
        FALL: begin
          if (w_tick) begin
            w_hold_next  = w_fall;
            w_state_next = (w_fall == '0) ? IDLE : FALL;
          end else begin
            w_hold_next = r_hold;
          end
        end
        default: begin
          w_state_next = IDLE;
          w_hold_next  = '0;
          w_hcnt_next  = '0;
        end
      endcase
    end
  end

  // Thermometer image of the next bar value, plus change detect.
  always_comb begin
    w_bar_next = '0;
    for (int i = 0; i < NSEG; i++) begin
      w_bar_next[i] = (LVL_W'(i) < w_cur_next);
    end
    w_chg = (w_cur_next != r_cur) || (w_hold_next != r_hold);
  end

  // Bar, hold FSM and update-pulse registers.
  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      r_cur   <= '0;
      r_bar   <= '0;
      r_hold  <= '0;
      r_hcnt  <= '0;
      r_state <= IDLE;
      r_chg   <= 1'b0;
      r_upd   <= 1'b0;
    end else begin
      r_cur   <= w_cur_next;
      r_bar   <= w_bar_next;
      r_hold  <= w_hold_next;
      r_hcnt  <= w_hcnt_next;
      r_state <= w_state_next;
      r_chg   <= w_chg;
      r_upd   <= r_chg;
    end
  end

  assign level    = r_lvl;
  assign bar      = r_bar;
  assign hold_seg = r_hold;
  assign upd      = r_upd;

endmodule
